// File: rtl/seq_detect_prog.sv
// Programmable Moore serial pattern detector: matches a bit-serial stream against a
// runtime-loadable pattern of 1..MAX_LEN bits, overlapping or non-overlapping.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b1011),
  parameter int                 DEF_LEN     = 4,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] nh;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   nf;
  logic               hit;
  logic               cfg_ok;

  generate
    if (MAX_LEN == 1) begin : g_shift_1
      assign nh = in;
    end else begin : g_shift_n
      assign nh = {hist[MAX_LEN-2:0], in};
    end
  endgenerate

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    nf     = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
    // Only the newest len bits take part; older history bits are masked off.
    hit    = (nf >= len) && (((nh ^ pat) & mask) == '0);
    cfg_ok = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat         <= DEF_PATTERN;
      len         <= LEN_W'(DEF_LEN);
      ovl         <= DEF_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      out         <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_load) begin
        // A load owns the edge: any coincident data bit is dropped.
        if (cfg_ok) begin
          pat         <= cfg_pattern;
          len         <= cfg_len;
          ovl         <= cfg_overlap;
          hist        <= '0;
          fill        <= '0;
          out         <= 1'b0;
          match_count <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (in_valid) begin
        hist <= nh;
        out  <= hit;
        fill <= (hit && !ovl) ? '0 : nf;
        if (hit && (match_count != '1)) begin
          match_count <= match_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios with spec-derived constants,
// then randomized traffic against a queue-based reference model.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst, in_valid, in, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       out, cfg_err, out_s, err_s;
  logic [7:0] match_count;
  logic [2:0] count_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detect_prog dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detect_prog #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .out(out_s), .match_count(count_s), .cfg_err(err_s)
  );

  // Reference model: list of bits accepted since the last clear, matched by suffix.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len, m_cnt, m_cnt3;
  bit         m_ovl, m_out, m_err;

  function automatic void model_edge(bit r, bit ld, logic [7:0] p, int l, bit o, bit v, bit b);
    bit hit;
    m_err = 1'b0;
    if (r) begin
      m_pat = 8'b1011; m_len = 4; m_ovl = 1'b1;
      mq.delete(); m_out = 1'b0; m_cnt = 0; m_cnt3 = 0;
    end else if (ld) begin
      if (l >= 1 && l <= 8) begin
        m_pat = p; m_len = l; m_ovl = o;
        mq.delete(); m_out = 1'b0; m_cnt = 0; m_cnt3 = 0;
      end else begin
        m_err = 1'b1;
      end
    end else if (v) begin
      mq.push_back(b);
      hit = (mq.size() >= m_len);
      for (int j = 0; j < m_len && hit; j++)
        if (mq[mq.size() - m_len + j] != m_pat[m_len - 1 - j]) hit = 1'b0;
      m_out = hit;
      if (hit) begin
        m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
        m_cnt3 = (m_cnt3 < 7)   ? m_cnt3 + 1 : 7;
        if (!m_ovl) mq.delete();
      end
      if (mq.size() > 16) void'(mq.pop_front());
    end
  endfunction

  task automatic cycle(input bit r, input bit ld, input logic [7:0] p, input logic [3:0] l,
                       input bit o, input bit v, input bit b);
    @(negedge clk);
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o; in_valid = v; in = b;
    @(posedge clk);
    model_edge(r, ld, p, int'(l), o, v, b);
    #1;
  endtask

  task automatic send(input bit b);
    cycle(1'b0, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom), 1'b1, b);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
    cycle(1'b0, 1'b1, p, l, o, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", out); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", match_count); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_default_overlap();
    logic [6:0] seq = 7'b1011011;
    logic [6:0] exp = 7'b0001001;
    for (int i = 0; i < 7; i++) begin
      send(seq[6-i]);
      checks++;
      if (out !== exp[6-i]) begin errors++; $display("FAIL ovl_bit%0d: out=%b want %b", i+1, out, exp[6-i]); end
    end
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL ovl_count: got %0d want 2", match_count); end
  endtask

  task automatic test_nonoverlap();
    logic [10:0] seq = 11'b1011011_1011;
    logic [10:0] exp = 11'b0001000_0001;
    load(8'b1011, 4'd4, 1'b0);
    checks++; if (cfg_err !== 1'b0 || match_count !== 8'd0) begin
      errors++; $display("FAIL nov_load: err=%b count=%0d want 0 0", cfg_err, match_count); end
    for (int i = 0; i < 11; i++) begin
      send(seq[10-i]);
      checks++;
      if (out !== exp[10-i]) begin errors++; $display("FAIL nov_bit%0d: out=%b want %b", i+1, out, exp[10-i]); end
    end
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL nov_count: got %0d want 2", match_count); end
  endtask

  task automatic test_len_extremes();
    logic [3:0]  s1 = 4'b1101;
    logic [15:0] s8 = 16'hA5A5;
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(s1[3-i]);
      checks++;
      if (out !== s1[3-i]) begin errors++; $display("FAIL len1_bit%0d: out=%b want %b", i+1, out, s1[3-i]); end
    end
    checks++; if (match_count !== 8'd3) begin errors++; $display("FAIL len1_count: got %0d want 3", match_count); end
    load(8'hA5, 4'd8, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send(s8[15-i]);
      checks++;
      if (out !== (i == 7 || i == 15)) begin
        errors++; $display("FAIL len8_bit%0d: out=%b want %b", i+1, out, (i == 7 || i == 15)); end
    end
    checks++; if (match_count !== 8'd2) begin errors++; $display("FAIL len8_count: got %0d want 2", match_count); end
  endtask

  task automatic test_valid_gaps();
    load(8'b1011, 4'd4, 1'b1);
    send(1); send(0); send(1); send(1);
    checks++; if (out !== 1'b1 || match_count !== 8'd1) begin
      errors++; $display("FAIL gap_match: out=%b count=%0d want 1 1", out, match_count); end
    for (int i = 0; i < 5; i++) begin
      idle();
      checks++; if (out !== 1'b1 || match_count !== 8'd1) begin
        errors++; $display("FAIL gap_hold%0d: out=%b count=%0d want 1 1", i, out, match_count); end
    end
    send(0);
    checks++; if (out !== 1'b0 || match_count !== 8'd1) begin
      errors++; $display("FAIL gap_fall: out=%b count=%0d want 0 1", out, match_count); end
  endtask

  task automatic test_illegal_cfg();
    load(8'hFF, 4'd0, 1'b0);
    checks++; if (cfg_err !== 1'b1 || match_count !== 8'd1) begin
      errors++; $display("FAIL bad0: err=%b count=%0d want 1 1", cfg_err, match_count); end
    idle();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL bad0_pulse: err=%b want 0", cfg_err); end
    load(8'hFF, 4'd9, 1'b0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL bad9: err=%b want 1", cfg_err); end
    send(1); send(0); send(1);
    checks++; if (out !== 1'b0 || cfg_err !== 1'b0) begin
      errors++; $display("FAIL bad_keep_pre: out=%b err=%b want 0 0", out, cfg_err); end
    send(1);
    checks++; if (out !== 1'b1 || match_count !== 8'd2) begin
      errors++; $display("FAIL bad_keep: out=%b count=%0d want 1 2", out, match_count); end
    // Legal load with a coincident bit: the bit must not enter history.
    cycle(1'b0, 1'b1, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b1);
    checks++; if (out !== 1'b0 || match_count !== 8'd0 || cfg_err !== 1'b0) begin
      errors++; $display("FAIL coin_load: out=%b count=%0d err=%b want 0 0 0", out, match_count, cfg_err); end
    send(0); send(1); send(1);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL coin_drop: out=%b want 0", out); end
    send(1); send(0);
    // Illegal load with a coincident bit: also dropped.
    cycle(1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL coin_bad_err: err=%b want 1", cfg_err); end
    send(1);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL coin_bad_a: out=%b want 0", out); end
    send(1);
    checks++; if (out !== 1'b1 || match_count !== 8'd1) begin
      errors++; $display("FAIL coin_bad_b: out=%b count=%0d want 1 1", out, match_count); end
  endtask

  task automatic test_saturation();
    load(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(1);
      checks++;
      if (count_s !== 3'((i + 1 > 7) ? 7 : i + 1)) begin
        errors++; $display("FAIL sat_%0d: count=%0d want %0d", i+1, count_s, (i + 1 > 7) ? 7 : i + 1); end
    end
    checks++; if (match_count !== 8'd10) begin errors++; $display("FAIL sat_wide: count=%0d want 10", match_count); end
  endtask

  task automatic test_reset_midstream();
    load(8'b1011, 4'd4, 1'b1);
    send(1); send(0); send(1);
    cycle(1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    checks++; if (out !== 1'b0 || match_count !== 8'd0 || cfg_err !== 1'b0 || count_s !== 3'd0) begin
      errors++; $display("FAIL rst_mid: out=%b count=%0d err=%b sat=%0d want 0 0 0 0",
                         out, match_count, cfg_err, count_s); end
    send(1);
    checks++; if (out !== 1'b0 || match_count !== 8'd0) begin
      errors++; $display("FAIL rst_hist: out=%b count=%0d want 0 0", out, match_count); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      bit         r, ld, o, v, b;
      logic [3:0] l;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 24) == 0);
      l  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      o  = 1'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      cycle(r, ld, 8'($urandom), l, o, v, b);
      checks++; if (out !== m_out) begin errors++; $display("FAIL rnd_out@%0d: got %b want %b", n, out, m_out); end
      checks++; if (match_count !== 8'(m_cnt)) begin
        errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, match_count, m_cnt); end
      checks++; if (cfg_err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", n, cfg_err, m_err); end
      checks++; if (count_s !== 3'(m_cnt3)) begin
        errors++; $display("FAIL rnd_sat@%0d: got %0d want %0d", n, count_s, m_cnt3); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    test_reset();
    test_default_overlap();
    test_nonoverlap();
    test_len_extremes();
    test_valid_gaps();
    test_illegal_cfg();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
